opb_register_bank_ppc2simulink: RTL and testbench

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

---
 rtl/opb_register_bank_ppc2simulink.sv | 138 +++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank bridging PowerPC software to fabric logic.
// Software writes a set of shadow registers, then commits them so that all
// active registers seen by the fabric change together in a single cycle.
//
// Ports:
//   OPB_Clk, OPB_Rst        - clock, synchronous active-high reset
//   OPB_ABus/BE/DBus/RNW/
//   OPB_select/seqAddr      - OPB slave request (bit 0 = MSB)
//   Sl_DBus/xferAck/errAck/
//   Sl_retry/toutSup        - OPB slave response
//   user_commit_req         - fabric-side commit strobe
//   user_data_out           - active registers, reg i on [32i+31:32i]
//   user_commit_pulse       - one-cycle pulse following each commit
//
// Map (offset from base): shadow i @ 0x00+4i, CTRL @ 0x40,
// active i (read-only) @ 0x80+4i; everything else acks and reads 0.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR    = 32'h01094600,
  parameter logic [31:0] C_HIGHADDR    = 32'h010946FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_REGS    = 2,
  parameter int          C_AUTO_COMMIT = 0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic                    user_commit_req,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic                    user_commit_pulse
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                         state_q, state_d;
  logic [C_NUM_REGS-1:0][31:0]    shadow_q, shadow_d;
  logic [C_NUM_REGS-1:0][31:0]    active_q, active_d;
  logic [15:0]                    count_q, count_d;
  logic                           pulse_q, pulse_d;
  logic [31:0]                    rdata_q, rdata_d;

  logic [31:0] abus, off, wdata, wmask, rdata;
  logic [5:0]  word;
  logic [3:0]  idx;
  logic        hit, wr, is_shadow, is_ctrl, is_active, commit;

  // Offset bits outside the 256-byte window and byte-lane bits are not decoded;
  // seqAddr is ignored since every beat is handled as a single transfer.
  logic unused_bits;
  assign unused_bits = &{1'b0, OPB_seqAddr, off[31:8], off[1:0]};

  always_comb begin
    abus      = OPB_ABus;
    off       = abus - C_BASEADDR;
    word      = off[7:2];
    idx       = word[3:0];
    is_shadow = (word[5:4] == 2'b00);
    is_ctrl   = (word == 6'h10);
    is_active = (word[5:4] == 2'b10);
    hit       = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR) &&
                (state_q == IDLE);
    wr        = hit && !OPB_RNW;
    wdata     = OPB_DBus;
    // BE[k] covers OPB byte k, which is user bits [31-8k:24-8k].
    wmask     = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};

    rdata = '0;
    if (is_ctrl) rdata = {count_q, 16'h0000};
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (is_shadow && idx == i[3:0]) rdata = shadow_q[i];
      if (is_active && idx == i[3:0]) rdata = active_q[i];
    end

    // Both commit sources collapse into one commit.
    commit = user_commit_req || (wr && is_ctrl && OPB_DBus[31]);

    shadow_d = shadow_q;
    active_d = active_q;
    // Commit copies pre-write shadows; a simultaneous write lands in shadow only.
    if (commit) active_d = shadow_q;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (wr && is_shadow && idx == i[3:0]) begin
        shadow_d[i] = (shadow_q[i] & ~wmask) | (wdata & wmask);
        if (C_AUTO_COMMIT != 0)
          active_d[i] = (active_d[i] & ~wmask) | (wdata & wmask);
      end
    end

    count_d = count_q + {15'd0, commit};
    pulse_d = commit;
    rdata_d = (hit && OPB_RNW) ? rdata : 32'h0;

    state_d = state_q;
    case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      pulse_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
      rdata_q  <= rdata_d;
    end
  end

  // Reset raised during the ACK cycle kills that ack immediately.
  assign Sl_xferAck        = (state_q == ACK) && !OPB_Rst;
  assign Sl_DBus           = Sl_xferAck ? rdata_q : 32'h0;
  assign Sl_errAck         = 1'b0;
  assign Sl_retry          = 1'b0;
  assign Sl_toutSup        = 1'b0;
  assign user_data_out     = active_q;
  assign user_commit_pulse = pulse_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
module tb_opb_register_bank_ppc2simulink;
  localparam logic [31:0] BASE = 32'h01094600;
  localparam logic [31:0] HIGH = 32'h010946FF;
  localparam int NR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rnw, sel, sel_ac, seq, ucr;
  logic [31:0] abus, dbus;
  logic [3:0]  be;
  logic [31:0] sdbus, sdbus_ac;
  logic        ack, err, rty, tout, pulse;
  logic        ack_ac, err_ac, rty_ac, tout_ac, pulse_ac;
  logic [63:0] udo, udo_ac;

  opb_register_bank_ppc2simulink dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sdbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(rty), .Sl_toutSup(tout),
    .user_commit_req(ucr), .user_data_out(udo), .user_commit_pulse(pulse));

  opb_register_bank_ppc2simulink #(.C_AUTO_COMMIT(1)) dut_ac (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel_ac), .OPB_seqAddr(seq),
    .Sl_DBus(sdbus_ac), .Sl_xferAck(ack_ac), .Sl_errAck(err_ac), .Sl_retry(rty_ac),
    .Sl_toutSup(tout_ac), .user_commit_req(ucr), .user_data_out(udo_ac),
    .user_commit_pulse(pulse_ac));

  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register file view of the address map.
  logic [31:0] sh [16];
  logic [31:0] act[16];
  logic [15:0] cnt;

  task automatic mreset();
    for (int i = 0; i < 16; i++) begin sh[i] = 0; act[i] = 0; end
    cnt = 0;
  endtask

  function automatic logic [31:0] mread(input int off);
    int w = off / 4;
    if (w < 16) return (w < NR) ? sh[w] : 32'h0;
    if (w == 16) return {cnt, 16'h0};
    if (w >= 32 && w < 48) return (w - 32 < NR) ? act[w - 32] : 32'h0;
    return 32'h0;
  endfunction

  task automatic mhit(input bit r, input int off, input logic [31:0] d, input logic [3:0] b,
                      input bit u, output bit cm);
    int w = off / 4;
    cm = u || (!r && w == 16 && d[0]);
    if (cm) begin
      for (int i = 0; i < NR; i++) act[i] = sh[i];
      cnt = cnt + 16'd1;
    end
    if (!r && w < NR)
      for (int j = 0; j < 4; j++) if (b[j]) sh[w][8*j +: 8] = d[8*j +: 8];
  endtask

  function automatic logic [63:0] mact();
    return {act[1], act[0]};
  endfunction

  task automatic xfer(input bit r, input int off, input logic [31:0] d, input logic [3:0] b,
                      input bit u, input string tag);
    logic [31:0] exp;
    bit cm;
    @(negedge clk);
    abus = BASE + off; dbus = d; be = b; rnw = r; sel = 1; ucr = u;
    exp = r ? mread(off) : 32'h0;
    @(posedge clk);
    mhit(r, off, d, b, u, cm);
    @(negedge clk);
    sel = 0; ucr = 0;
    chk({tag, " ack"}, ack, 1);
    chk({tag, " rdata"}, sdbus, exp);
    chk({tag, " pulse"}, pulse, cm);
    chk({tag, " active"}, udo, mact());
    @(negedge clk);
    chk({tag, " ack_end"}, {ack, pulse}, 0);
    chk({tag, " dbus_idle"}, sdbus, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; sel = 0; sel_ac = 0; ucr = 0;
    @(negedge clk); rst = 0;
    mreset();
  endtask

  initial begin
    rst = 1; rnw = 0; sel = 0; sel_ac = 0; seq = 0; ucr = 0;
    abus = 0; dbus = 0; be = 0;
    mreset();
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset udo", udo, 0);
    chk("reset ack/pulse", {ack, pulse}, 0);
    chk("reset dbus", sdbus, 0);
    chk("const outs", {err, rty, tout, err_ac, rty_ac, tout_ac}, 0);

    // Basic write, commit, byte enables.
    xfer(0, 'h00, 32'hDEADBEEF, 4'hF, 0, "w_sh0");
    xfer(1, 'h00, 0, 4'hF, 0, "r_sh0");
    xfer(0, 'h00, 32'h11111111, 4'hF, 0, "w_sh0b");
    xfer(0, 'h04, 32'h22222222, 4'hF, 0, "w_sh1");
    xfer(0, 'h40, 32'h00000001, 4'hF, 0, "commit");
    xfer(1, 'h40, 0, 4'hF, 0, "r_ctrl");
    xfer(1, 'h84, 0, 4'hF, 0, "r_act1");
    xfer(0, 'h00, 32'h0, 4'hF, 0, "clr_sh0");
    xfer(0, 'h00, 32'hAABBCCDD, 4'b0100, 0, "be0100");
    xfer(1, 'h00, 0, 4'hF, 0, "r_be");
    // Coincident commit sources, write during commit.
    xfer(0, 'h40, 32'h1, 4'hF, 1, "dual_commit");
    xfer(0, 'h04, 32'h33333333, 4'hF, 1, "wr_commit");
    xfer(1, 'h40, 0, 4'hF, 0, "r_ctrl2");
    xfer(1, 'h04, 0, 4'hF, 0, "r_sh1");
    xfer(0, 'h40, 32'hFFFFFFFE, 4'hF, 0, "ctrl_nocommit");
    // Holes, out-of-range index, read-only actives, top of window.
    xfer(1, 'h44, 0, 4'hF, 0, "r_hole");
    xfer(1, 'h08, 0, 4'hF, 0, "r_idx2");
    xfer(0, 'h08, 32'h12345678, 4'hF, 0, "w_idx2");
    xfer(0, 'h80, 32'h12345678, 4'hF, 0, "w_act0");
    xfer(1, 'hFF, 0, 4'hF, 0, "r_top");

    // Outside the window: never acked.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); abus = (k == 0) ? HIGH + 1 : BASE - 1; rnw = 1; sel = 1;
      repeat (3) begin @(negedge clk); chk("oow no_ack", ack, 0); end
      sel = 0;
    end

    // Select held through ACK: next acceptance only after returning to IDLE.
    @(negedge clk); abus = BASE; rnw = 1; sel = 1;
    @(negedge clk); chk("hold ack1", ack, 1);
    @(negedge clk); chk("hold gap", ack, 0);
    @(negedge clk); chk("hold ack2", ack, 1); chk("hold data", sdbus, mread(0));
    sel = 0;
    @(negedge clk);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int cat, off;
      cat = $urandom_range(0, 5);
      case (cat)
        0, 5: off = 4 * $urandom_range(0, 3);
        1:    off = 'h40;
        2:    off = 'h80 + 4 * $urandom_range(0, 3);
        3:    off = 'h44 + 4 * $urandom_range(0, 14);
        default: off = 'hC0 + 4 * $urandom_range(0, 15);
      endcase
      xfer($urandom_range(0, 1), off, $urandom, $urandom_range(0, 15),
           $urandom_range(0, 3) == 0, "rand");
    end

    // Reset in ACK cycle suppresses the ack and its data.
    xfer(0, 'h00, 32'h00001234, 4'hF, 0, "pre_rst");
    @(negedge clk); abus = BASE; rnw = 1; sel = 1;
    @(negedge clk); sel = 0; rst = 1; #1;
    chk("rst_ack ack", ack, 0);
    chk("rst_ack dbus", sdbus, 0);
    @(negedge clk); rst = 0; mreset();
    chk("rst_ack after", {udo, ack, pulse}, 0);
    chk("rst_ack dbus2", sdbus, 0);
    xfer(1, 'h00, 0, 4'hF, 0, "r_after_rst");

    // Reset wins over a commit in the same cycle.
    xfer(0, 'h00, 32'h0000CAFE, 4'hF, 0, "pre_rstc");
    @(negedge clk); ucr = 1; rst = 1;
    @(negedge clk); ucr = 0; rst = 0; mreset();
    chk("rst_commit udo", udo, 0);
    chk("rst_commit pulse", pulse, 0);
    xfer(1, 'h40, 0, 4'hF, 0, "rst_commit cnt");

    // Commit counter wrap.
    do_reset();
    @(negedge clk); ucr = 1;
    repeat (65535) begin @(posedge clk); cnt = cnt + 16'd1; end
    @(negedge clk); ucr = 0;
    xfer(1, 'h40, 0, 4'hF, 0, "cnt_ffff");
    xfer(0, 'h40, 32'h1, 4'hF, 0, "cnt_wrap_commit");
    xfer(1, 'h40, 0, 4'hF, 0, "cnt_wrap");

    // Auto-commit instance.
    @(negedge clk); abus = BASE; dbus = 32'h5; be = 4'hF; rnw = 0; sel_ac = 1;
    @(negedge clk); sel_ac = 0;
    chk("ac ack", ack_ac, 1);
    chk("ac active0", udo_ac, 64'h5);
    chk("ac pulse", pulse_ac, 0);
    @(negedge clk); abus = BASE; dbus = 32'hAABBCCDD; be = 4'b0100; sel_ac = 1;
    @(negedge clk); sel_ac = 0;
    chk("ac masked", udo_ac, 64'h00BB0005);
    chk("ac pulse2", pulse_ac, 0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
